integral_window: RTL and testbench

Parametrised streaming integral-image engine for the face-detection datapath. It accepts one window of WIN_W × WIN_H pixels in raster order over a valid/ready handshake and builds the summed-area table incrementally, using a row accumulator and a one-row line buffer. It holds the table in an internal array for random-access readback by the downstream Haar-feature evaluator. It generalises the fixed 20×20 window engine to arbitrary window size, pixel width and sum width. It adds backpressure, abort/restart and an optional squared-integral table for variance normalisation.

---
 rtl/integral_window.sv | 160 ++++++++++++++++
 tb/tb_integral_window.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/integral_window.sv
// Streaming summed-area table builder for one WIN_W x WIN_H window with registered readback.
// Optional squared-integral table is enabled by defining SQ_INTEGRAL_EN.
module integral_window #(
    parameter int PIX_W = 8,
    parameter int WIN_W = 20,
    parameter int WIN_H = 20,
    parameter int SUM_W = 32,
    parameter int AW    = $clog2(WIN_W*WIN_H)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             PIX_VALID,
    input  logic [PIX_W-1:0] PIX_IN,
    output logic             PIX_READY,
    output logic             DONE,
    input  logic [AW-1:0]    RD_ADDR,
    output logic [SUM_W-1:0] RD_DATA,
    output logic [SUM_W-1:0] SQ_RD_DATA,
    output logic [1:0]       STATE_DBG
);

    localparam int N  = WIN_W * WIN_H;
    localparam int CW = $clog2(WIN_W);
    localparam int RW = $clog2(WIN_H);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FILL     = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [AW-1:0]    wr_addr;
    logic [SUM_W-1:0] rs;

    logic [SUM_W-1:0] table_mem [N];
    logic [SUM_W-1:0] lb        [WIN_W];

    logic             accept;
    logic             col_last;
    logic             row_last;
    logic             addr_ok;
    logic [SUM_W-1:0] pix_ext;
    logic [SUM_W-1:0] rs_next;
    logic [SUM_W-1:0] lb_rd;
    logic [SUM_W-1:0] ii;

    // Handshake: a pixel transfers on a cycle where PIX_VALID and PIX_READY are both high;
    // START takes priority, so READY drops in any cycle START is asserted.
    assign PIX_READY = (state == FILL) && !START;
    assign accept    = PIX_VALID && PIX_READY;
    assign col_last  = (col == CW'(WIN_W - 1));
    assign row_last  = (row == RW'(WIN_H - 1));
    assign addr_ok   = ({1'b0, RD_ADDR} < (AW + 1)'(N));
    assign STATE_DBG = state;

    always_comb begin
        pix_ext = SUM_W'(PIX_IN);
        rs_next = ((col == '0) ? '0 : rs) + pix_ext;
        lb_rd   = (row == '0) ? '0 : lb[col];
        ii      = rs_next + lb_rd;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            DONE    <= 1'b0;
            col     <= '0;
            row     <= '0;
            wr_addr <= '0;
            rs      <= '0;
        end else if (START) begin
            state   <= FILL;
            DONE    <= 1'b0;
            col     <= '0;
            row     <= '0;
            wr_addr <= '0;
            rs      <= '0;
        end else if (accept) begin
            rs      <= rs_next;
            wr_addr <= wr_addr + AW'(1);
            if (col_last) begin
                col <= '0;
                if (row_last) begin
                    row   <= '0;
                    state <= COMPLETE;
                    DONE  <= 1'b1;
                end else begin
                    row <= row + RW'(1);
                end
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Storage is deliberately not reset: table contents survive RESET.
    always_ff @(posedge CLK) begin
        if (accept) begin
            table_mem[wr_addr] <= ii;
            lb[col]            <= ii;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            RD_DATA <= '0;
        end else if (addr_ok) begin
            RD_DATA <= table_mem[RD_ADDR];
        end else begin
            RD_DATA <= '0;
        end
    end

`ifdef SQ_INTEGRAL_EN
    logic [SUM_W-1:0]   sq_rs;
    logic [SUM_W-1:0]   sq_table [N];
    logic [SUM_W-1:0]   sq_lb    [WIN_W];
    logic [2*PIX_W-1:0] sq_pix;
    logic [SUM_W-1:0]   sq_rs_next;
    logic [SUM_W-1:0]   sq_ii;

    always_comb begin
        sq_pix     = PIX_IN * PIX_IN;
        sq_rs_next = ((col == '0) ? '0 : sq_rs) + SUM_W'(sq_pix);
        sq_ii      = sq_rs_next + ((row == '0) ? '0 : sq_lb[col]);
    end

    always_ff @(posedge CLK) begin
        if (RESET || START) begin
            sq_rs <= '0;
        end else if (accept) begin
            sq_rs <= sq_rs_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            sq_table[wr_addr] <= sq_ii;
            sq_lb[col]        <= sq_ii;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            SQ_RD_DATA <= '0;
        end else if (addr_ok) begin
            SQ_RD_DATA <= sq_table[RD_ADDR];
        end else begin
            SQ_RD_DATA <= '0;
        end
    end
`else
    assign SQ_RD_DATA = '0;
`endif

endmodule

// File: tb/tb_integral_window.sv
// Self-checking bench for integral_window: random stimulus against a summed-area model,
// plus hand-computed readbacks for the default and a 4x3 geometry.
module tb_integral_window;

    localparam int N = 400;

    logic        CLK = 1'b0;
    logic        RESET, START, PIX_VALID;
    logic [7:0]  PIX_IN;
    logic        PIX_READY, DONE;
    logic [8:0]  RD_ADDR;
    logic [31:0] RD_DATA, SQ_RD_DATA;
    logic [1:0]  STATE_DBG;

    logic        s_start, s_valid;
    logic [7:0]  s_pix;
    logic        s_ready, s_done;
    logic [3:0]  s_addr;
    logic [31:0] s_rd, s_sq;
    logic [1:0]  s_state;

    int checks = 0;
    int errors = 0;

    // Model state
    bit          m_live = 0;
    bit          m_fill = 0;
    bit          m_done = 0;
    int          m_cnt  = 0;
    int          pix_m   [N];
    logic [31:0] m_tab   [N];
    logic [31:0] m_sqtab [N];
    bit          m_known [N];
    logic [31:0] exp_rd, exp_sq;
    bit          rd_known = 0;
    bit          rd_hold  = 0;

    integral_window dut (
        .CLK(CLK), .RESET(RESET), .START(START), .PIX_VALID(PIX_VALID), .PIX_IN(PIX_IN),
        .PIX_READY(PIX_READY), .DONE(DONE), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA),
        .SQ_RD_DATA(SQ_RD_DATA), .STATE_DBG(STATE_DBG)
    );

    integral_window #(.PIX_W(8), .WIN_W(4), .WIN_H(3), .SUM_W(32)) u_small (
        .CLK(CLK), .RESET(RESET), .START(s_start), .PIX_VALID(s_valid), .PIX_IN(s_pix),
        .PIX_READY(s_ready), .DONE(s_done), .RD_ADDR(s_addr), .RD_DATA(s_rd),
        .SQ_RD_DATA(s_sq), .STATE_DBG(s_state)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each entry is the plain sum of all pixels above-left of it, inclusive.
    always @(posedge CLK) begin
        if (RESET) begin
            m_live = 1; m_fill = 0; m_done = 0; m_cnt = 0;
            exp_rd = 0; exp_sq = 0; rd_known = 1;
        end else if (m_live) begin
            if (RD_ADDR >= N) begin
                exp_rd = 0; exp_sq = 0; rd_known = 1;
            end else begin
                rd_known = m_known[RD_ADDR];
                exp_rd   = m_tab[RD_ADDR];
                exp_sq   = m_sqtab[RD_ADDR];
            end
            if (START) begin
                m_fill = 1; m_done = 0; m_cnt = 0;
            end else if (m_fill && PIX_VALID) begin
                int r, c;
                logic [31:0] s, q;
                pix_m[m_cnt] = PIX_IN;
                r = m_cnt / 20; c = m_cnt % 20; s = 0; q = 0;
                for (int i = 0; i <= r; i++)
                    for (int j = 0; j <= c; j++) begin
                        s += pix_m[i*20+j];
                        q += pix_m[i*20+j] * pix_m[i*20+j];
                    end
                m_tab[m_cnt] = s;
`ifdef SQ_INTEGRAL_EN
                m_sqtab[m_cnt] = q;
`else
                m_sqtab[m_cnt] = 0;
`endif
                m_known[m_cnt] = 1;
                m_cnt++;
                if (m_cnt == N) begin
                    m_fill = 0; m_done = 1;
                end
            end
        end
    end

    // Per-cycle compare, sampled mid-low-phase after the driver has settled the inputs.
    always begin
        @(negedge CLK);
        #1;
        if (m_live) begin
            chk("pix_ready", 32'(PIX_READY), 32'(m_fill && !START));
            chk("done", 32'(DONE), 32'(m_done));
            if (rd_known) begin
                chk("rd_data", RD_DATA, exp_rd);
                chk("sq_rd_data", SQ_RD_DATA, exp_sq);
            end
        end
    end

    always @(negedge CLK) if (!rd_hold) RD_ADDR = 9'($urandom_range(0, 511));

    task automatic start_pulse();
        @(negedge CLK);
        START = 1; PIX_VALID = 0;
        @(negedge CLK);
        START = 0;
    endtask

    // mode 0: constant val, mode 1: pixel = column, mode 2: random
    task automatic drive_pixels(input int n, input int mode, input int val, input int stall);
        int acc = 0;
        int cyc = 0;
        bit rdy;
        while (acc < n && cyc < 20000) begin
            @(negedge CLK);
            PIX_VALID = ($urandom_range(0, 99) >= stall);
            case (mode)
                0:       PIX_IN = 8'(val);
                1:       PIX_IN = 8'(acc % 20);
                default: PIX_IN = 8'($urandom_range(0, 255));
            endcase
            #1 rdy = PIX_READY;
            @(posedge CLK);
            if (PIX_VALID && rdy) acc++;
            cyc++;
        end
        if (acc < n) chk("drive_timeout", 32'(acc), 32'(n));
    endtask

    task automatic end_window_chk(input string name);
        @(negedge CLK);
        PIX_VALID = 0;
        #2 chk(name, 32'(DONE), 32'd1);
    endtask

    task automatic read_chk(input string name, input int a, input bit sq, input logic [31:0] e);
        rd_hold = 1;
        @(negedge CLK);
        RD_ADDR = 9'(a);
        @(negedge CLK);
        #2 chk(name, sq ? SQ_RD_DATA : RD_DATA, e);
        rd_hold = 0;
    endtask

    task automatic ones_window(input string tag);
        start_pulse();
        drive_pixels(400, 0, 1, 0);
        end_window_chk({tag, "_done_latency"});
        for (int k = 0; k < 4; k++) begin
            int r, c;
            r = $urandom_range(0, 19); c = $urandom_range(0, 19);
            read_chk({tag, "_rc"}, r*20+c, 0, 32'((r+1)*(c+1)));
        end
        read_chk({tag, "_addr399"}, 399, 0, 32'd400);
        read_chk({tag, "_addr450"}, 450, 0, 32'd0);
    endtask

    initial begin
        RESET = 1; START = 0; PIX_VALID = 0; PIX_IN = 0;
        s_start = 0; s_valid = 0; s_pix = 0; s_addr = 0;
        repeat (3) @(negedge CLK);
        RESET = 0;
        #2;
        chk("reset_done", 32'(DONE), 32'd0);
        chk("reset_ready", 32'(PIX_READY), 32'd0);
        chk("reset_rd", RD_DATA, 32'd0);
        chk("reset_sq", SQ_RD_DATA, 32'd0);

        ones_window("ones");

        // Column ramp with ~40% stalls
        start_pulse();
        drive_pixels(400, 1, 0, 40);
        end_window_chk("ramp_done");
        read_chk("ramp_addr19", 19, 0, 32'd190);
        read_chk("ramp_addr399", 399, 0, 32'd3800);

        // Abort and restart, second START collides with a valid pixel
        start_pulse();
        drive_pixels(150, 0, 7, 0);
        @(negedge CLK);
        START = 1; PIX_VALID = 1; PIX_IN = 8'd9;
        #2 chk("abort_ready_low", 32'(PIX_READY), 32'd0);
        @(negedge CLK);
        START = 0; PIX_VALID = 0;
        drive_pixels(400, 0, 2, 0);
        end_window_chk("abort_done");
        read_chk("abort_addr0", 0, 0, 32'd2);
        read_chk("abort_addr399", 399, 0, 32'd800);

        // Reset mid-window
        start_pulse();
        drive_pixels(200, 2, 0, 20);
        @(negedge CLK);
        PIX_VALID = 0; RESET = 1;
        @(negedge CLK);
        RESET = 0;
        #2;
        chk("midrst_done", 32'(DONE), 32'd0);
        chk("midrst_ready", 32'(PIX_READY), 32'd0);
        chk("midrst_rd", RD_DATA, 32'd0);
        ones_window("rerun");

        // Random pixels, model-checked throughout
        start_pulse();
        drive_pixels(400, 2, 0, 25);
        end_window_chk("rand_done");

        // Maximum pixel value, plain and squared tables
        start_pulse();
        drive_pixels(400, 0, 255, 0);
        end_window_chk("max_done");
        read_chk("max_addr399", 399, 0, 32'd102000);
`ifdef SQ_INTEGRAL_EN
        read_chk("sq_addr399", 399, 1, 32'd26010000);
        read_chk("sq_addr0", 0, 1, 32'd65025);
`else
        read_chk("sq_addr399", 399, 1, 32'd0);
        read_chk("sq_addr0", 0, 1, 32'd0);
`endif

        // Small 4x3 geometry, all pixels 255
        @(negedge CLK);
        s_start = 1;
        @(negedge CLK);
        s_start = 0; s_valid = 1; s_pix = 8'd255;
        #2 chk("small_ready", 32'(s_ready), 32'd1);
        repeat (11) @(negedge CLK);
        #2 chk("small_done_early", 32'(s_done), 32'd0);
        @(negedge CLK);
        s_valid = 0;
        #2;
        chk("small_done", 32'(s_done), 32'd1);
        chk("small_ready_done", 32'(s_ready), 32'd0);
        s_addr = 4'd11;
        @(negedge CLK);
        #2 chk("small_addr11", s_rd, 32'd3060);
        s_addr = 4'd3;
        @(negedge CLK);
        #2 chk("small_addr3", s_rd, 32'd1020);
        s_addr = 4'd13;
        @(negedge CLK);
        #2 chk("small_addr13", s_rd, 32'd0);

        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
